// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer: rebuilds bytes from the PHY nibble stream (low nibble first)
// and reports per-frame length, error flags and good/error frame counters.
module phy_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 2047
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [3:0]  phy_rx_data,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_sof,
  output logic        r_frame_valid,
  output logic [23:0] r_ctrl_out,
  output logic [2:0]  r_frame_err,
  output logic [15:0] r_good_cnt,
  output logic [15:0] r_err_cnt
);

  localparam int unsigned LEN_W = 12;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    IDLE    = 3'd1,
    RX_HI   = 3'd2,
    RX_LO   = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         low_q, low_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sof_pend_q, sof_pend_d;
  logic               ovs_q, ovs_d;
  logic               par_q, par_d;       // parity of nibbles dropped while discarding
  logic [7:0]         data_q, data_d;
  logic               dval_q, dval_d;
  logic               sof_q, sof_d;
  logic               fval_q, fval_d;
  logic [23:0]        ctrl_q, ctrl_d;
  logic [2:0]         err_q, err_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]   bad_q, bad_d;

  logic               end_frame_c;
  logic               odd_c;
  logic [2:0]         err_c;
  logic [LEN_W-1:0]   len_inc_c;

  // Next-state and next-output computation for the deframing FSM
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    len_d       = len_q;
    sof_pend_d  = sof_pend_q;
    ovs_d       = ovs_q;
    par_d       = par_q;
    data_d      = data_q;
    dval_d      = 1'b0;
    sof_d       = 1'b0;
    fval_d      = 1'b0;
    ctrl_d      = ctrl_q;
    err_d       = err_q;
    good_d      = good_q;
    bad_d       = bad_q;
    end_frame_c = 1'b0;
    odd_c       = 1'b0;
    len_inc_c   = len_q + LEN_W'(1);

    case (state_q)
      SYNC: begin
        if (!phy_rx_dv) state_d = IDLE;
      end
      IDLE: begin
        if (phy_rx_dv) begin
          low_d      = phy_rx_data;
          len_d      = '0;
          sof_pend_d = 1'b1;
          ovs_d      = 1'b0;
          par_d      = 1'b0;
          state_d    = RX_HI;
        end
      end
      RX_HI: begin
        if (phy_rx_dv) begin
          data_d     = {phy_rx_data, low_q};
          dval_d     = 1'b1;
          sof_d      = sof_pend_q;
          sof_pend_d = 1'b0;
          len_d      = len_inc_c;
          state_d    = (len_inc_c == LEN_W'(MAX_LEN)) ? DISCARD : RX_LO;
        end else begin
          end_frame_c = 1'b1;
          odd_c       = 1'b1;
          state_d     = IDLE;
        end
      end
      RX_LO: begin
        if (phy_rx_dv) begin
          low_d   = phy_rx_data;
          state_d = RX_HI;
        end else begin
          end_frame_c = 1'b1;
          state_d     = IDLE;
        end
      end
      DISCARD: begin
        if (phy_rx_dv) begin
          ovs_d = 1'b1;
          par_d = ~par_q;
        end else begin
          end_frame_c = 1'b1;
          odd_c       = par_q;
          state_d     = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase

    err_c = {ovs_q, (len_q < LEN_W'(MIN_LEN)), odd_c};

    if (end_frame_c) begin
      fval_d = 1'b1;
      ctrl_d = {len_q, len_q};
      err_d  = err_c;
      if (err_c == 3'b000) good_d = good_q + CNT_W'(1);
      else                 bad_d  = bad_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_phy) begin
    if (reset) begin
      state_q    <= SYNC;
      low_q      <= '0;
      len_q      <= '0;
      sof_pend_q <= 1'b0;
      ovs_q      <= 1'b0;
      par_q      <= 1'b0;
      data_q     <= '0;
      dval_q     <= 1'b0;
      sof_q      <= 1'b0;
      fval_q     <= 1'b0;
      ctrl_q     <= '0;
      err_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      len_q      <= len_d;
      sof_pend_q <= sof_pend_d;
      ovs_q      <= ovs_d;
      par_q      <= par_d;
      data_q     <= data_d;
      dval_q     <= dval_d;
      sof_q      <= sof_d;
      fval_q     <= fval_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign r_data_out    = data_q;
  assign r_data_valid  = dval_q;
  assign r_sof         = sof_q;
  assign r_frame_valid = fval_q;
  assign r_ctrl_out    = ctrl_q;
  assign r_frame_err   = err_q;
  assign r_good_cnt    = good_q;
  assign r_err_cnt     = bad_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Testbench for phy_rx_deframer: two instances (default MAX_LEN and MAX_LEN=100)
// checked against a frame-level model built from nibble counts.
module tb_phy_rx_deframer;
  localparam int MIN_LEN = 64;
  localparam int MAX0    = 2047;
  localparam int MAX1    = 100;

  typedef struct packed {
    logic [23:0] ctrl;
    logic [2:0]  err;
    logic [15:0] good;
    logic [15:0] bad;
  } fev_t;

  logic clk_phy = 1'b0;
  always #5 clk_phy = ~clk_phy;

  logic        reset;
  logic [3:0]  rxd    [2];
  logic        rx_dv  [2];
  logic [7:0]  dout   [2];
  logic        dval   [2];
  logic        sof    [2];
  logic        fval   [2];
  logic [23:0] ctrl   [2];
  logic [2:0]  ferr   [2];
  logic [15:0] gcnt   [2];
  logic [15:0] ecnt   [2];

  phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX0)) u_dut0 (
    .clk_phy(clk_phy), .reset(reset), .phy_rx_data(rxd[0]), .phy_rx_dv(rx_dv[0]),
    .r_data_out(dout[0]), .r_data_valid(dval[0]), .r_sof(sof[0]), .r_frame_valid(fval[0]),
    .r_ctrl_out(ctrl[0]), .r_frame_err(ferr[0]), .r_good_cnt(gcnt[0]), .r_err_cnt(ecnt[0]));

  phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX1)) u_dut1 (
    .clk_phy(clk_phy), .reset(reset), .phy_rx_data(rxd[1]), .phy_rx_dv(rx_dv[1]),
    .r_data_out(dout[1]), .r_data_valid(dval[1]), .r_sof(sof[1]), .r_frame_valid(fval[1]),
    .r_ctrl_out(ctrl[1]), .r_frame_err(ferr[1]), .r_good_cnt(gcnt[1]), .r_err_cnt(ecnt[1]));

  // Observed byte and frame-end events, captured away from the active edge
  logic [8:0] obs_b [2][$];
  fev_t       obs_f [2][$];
  always @(negedge clk_phy) begin
    for (int d = 0; d < 2; d++) begin
      if (dval[d] === 1'b1) obs_b[d].push_back({sof[d], dout[d]});
      if (fval[d] === 1'b1) obs_f[d].push_back({ctrl[d], ferr[d], gcnt[d], ecnt[d]});
    end
  end

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  stim [$];
  logic [8:0]  exp_b [2][$];
  fev_t        exp_f [2][$];
  int          rp_b [2];
  int          rp_f [2];
  logic [15:0] mg [2];
  logic [15:0] me [2];

  // Single comparison with failure reporting
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: bytes are nibble pairs, capped at MAX_LEN
  task automatic model(input int d);
    int n, mx, len;
    logic [2:0] e;
    fev_t f;
    n   = stim.size();
    mx  = (d == 0) ? MAX0 : MAX1;
    len = n / 2;
    if (len > mx) len = mx;
    e[0] = (n % 2) == 1;
    e[1] = len < MIN_LEN;
    e[2] = n > 2 * mx;
    for (int i = 0; i < len; i++)
      exp_b[d].push_back({(i == 0), stim[2*i+1], stim[2*i]});
    if (e == 3'b000) mg[d] = mg[d] + 16'd1;
    else             me[d] = me[d] + 16'd1;
    f = {12'(len), 12'(len), e, mg[d], me[d]};
    exp_f[d].push_back(f);
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(4'($urandom));
  endtask

  task automatic send(input int d, input int gap);
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk_phy);
      rx_dv[d] = 1'b1;
      rxd[d]   = stim[i];
    end
    @(negedge clk_phy);
    rx_dv[d] = 1'b0;
    rxd[d]   = 4'($urandom);
    repeat (gap - 1) @(negedge clk_phy);
    model(d);
  endtask

  task automatic check(input int d);
    int nb, nf;
    repeat (3) @(negedge clk_phy);
    nb = obs_b[d].size() - rp_b[d];
    nf = obs_f[d].size() - rp_f[d];
    chk("byte_count", 64'(nb), 64'(exp_b[d].size()));
    for (int i = 0; i < nb && i < exp_b[d].size(); i++)
      chk("byte", 64'(obs_b[d][rp_b[d]+i]), 64'(exp_b[d][i]));
    chk("frame_count", 64'(nf), 64'(exp_f[d].size()));
    for (int i = 0; i < nf && i < exp_f[d].size(); i++)
      chk("frame", 64'(obs_f[d][rp_f[d]+i]), 64'(exp_f[d][i]));
    rp_b[d] = obs_b[d].size();
    rp_f[d] = obs_f[d].size();
    exp_b[d].delete();
    exp_f[d].delete();
  endtask

  task automatic check_zero(input int d);
    chk("rst_data", 64'(dout[d]), 64'h0);
    chk("rst_dval", 64'(dval[d]), 64'h0);
    chk("rst_sof",  64'(sof[d]),  64'h0);
    chk("rst_fval", 64'(fval[d]), 64'h0);
    chk("rst_ctrl", 64'(ctrl[d]), 64'h0);
    chk("rst_err",  64'(ferr[d]), 64'h0);
    chk("rst_good", 64'(gcnt[d]), 64'h0);
    chk("rst_bad",  64'(ecnt[d]), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rx_dv[d] = 1'b0; rxd[d] = 4'h0; rp_b[d] = 0; rp_f[d] = 0; mg[d] = '0; me[d] = '0;
    end
    repeat (3) @(negedge clk_phy);
    check_zero(0);
    check_zero(1);
    reset = 1'b0;
    @(negedge clk_phy);

    // 512-byte frame of 0,F nibbles
    stim.delete();
    for (int i = 0; i < 512; i++) begin stim.push_back(4'h0); stim.push_back(4'hF); end
    send(0, 1);
    check(0);

    // two back-to-back 64-byte frames with one gap cycle
    fill_rand(128); send(0, 1);
    fill_rand(128); send(0, 1);
    check(0);

    // runt frame
    fill_rand(126); send(0, 1);
    check(0);

    // odd nibble count
    fill_rand(129); send(0, 2);
    check(0);

    // oversize, exact-max and odd oversize on the MAX_LEN=100 instance
    fill_rand(300); send(1, 1);
    fill_rand(200); send(1, 1);
    fill_rand(201); send(1, 1);
    fill_rand(199); send(1, 3);
    check(1);

    // random lengths on both instances
    for (int k = 0; k < 6; k++) begin
      fill_rand(int'($urandom_range(1, 300)));
      send(0, int'($urandom_range(1, 3)));
    end
    check(0);
    for (int k = 0; k < 6; k++) begin
      fill_rand(int'($urandom_range(1, 260)));
      send(1, int'($urandom_range(1, 3)));
    end
    check(1);

    // one-cycle reset at byte 200 of a 512-byte frame; dv stays high to frame end
    fill_rand(1024);
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk_phy);
      reset    = (i == 400);
      rx_dv[0] = 1'b1;
      rxd[0]   = stim[i];
      if (i == 401) begin
        check_zero(0);
        check_zero(1);
        for (int d = 0; d < 2; d++) begin
          rp_b[d] = obs_b[d].size(); rp_f[d] = obs_f[d].size(); mg[d] = '0; me[d] = '0;
        end
      end
    end
    @(negedge clk_phy);
    rx_dv[0] = 1'b0;
    check(0);
    fill_rand(128); send(0, 1);
    check(0);
    chk("post_rst_good", 64'(gcnt[0]), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
